// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter.
// Holds the fetch PC and the branch-delay-slot flag for the instruction at
// that PC, and selects the next PC from exception, eret, stall, jr, jump,
// branch or sequential sources, highest priority first.
//
// Ports:
//   clk, reset     pipeline clock; asynchronous active-high reset
//   stall          freeze IF (pc and bd hold)
//   excReq         CP0 exception/interrupt redirect to the handler
//   eretD, epc     eret in ID, redirect to epc
//   pcD            PC of the instruction in ID
//   isBranchD      ID holds a conditional branch; cmpRes = taken
//   isJD, isJrD    ID holds j/jal or jr/jalr
//   imm16D         branch offset (words, signed)
//   index26D       jump index field
//   jrTargetD      forwarded rs for jr/jalr
//   pcF            fetch address
//   bdF            instruction at pcF sits in a delay slot
//   adelF          fetch address error (misaligned or out of range), combinational
module pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        excReq,
    input  logic        eretD,
    input  logic [31:0] epc,
    input  logic [31:0] pcD,
    input  logic        isBranchD,
    input  logic        cmpRes,
    input  logic        isJD,
    input  logic        isJrD,
    input  logic [15:0] imm16D,
    input  logic [25:0] index26D,
    input  logic [31:0] jrTargetD,
    output logic [31:0] pcF,
    output logic        bdF,
    output logic        adelF
);

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC  = 32'h0000_3000;
    localparam logic [PC_W-1:0] EXC_PC    = 32'h0000_4180;
    localparam logic [PC_W-1:0] FETCH_LO  = 32'h0000_3000;
    localparam logic [PC_W-1:0] FETCH_HI  = 32'h0000_6FFC;

    logic [PC_W-1:0] r_pc;
    logic            r_bd;

    logic [PC_W-1:0] w_pc_next;
    logic            w_bd_next;
    logic [PC_W-1:0] w_pcd_plus4;
    logic [PC_W-1:0] w_br_offset;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_j_target;

    // Control-transfer targets, all relative to the ID instruction.
    assign w_pcd_plus4 = pcD + PC_W'(4);
    assign w_br_offset = {{14{imm16D[15]}}, imm16D, 2'b00};
    assign w_br_target = w_pcd_plus4 + w_br_offset;
    assign w_j_target  = {w_pcd_plus4[31:28], index26D, 2'b00};

    // Next-PC select; redirects from CP0 beat stall and clear the delay-slot flag.
    always_comb begin
        w_pc_next = r_pc + PC_W'(4);
        w_bd_next = isBranchD | isJD | isJrD;
        if (excReq) begin
            w_pc_next = EXC_PC;
            w_bd_next = 1'b0;
        end else if (eretD) begin
            w_pc_next = epc;
            w_bd_next = 1'b0;
        end else if (stall) begin
            w_pc_next = r_pc;
            w_bd_next = r_bd;
        end else if (isJrD) begin
            w_pc_next = jrTargetD;
        end else if (isJD) begin
            w_pc_next = w_j_target;
        end else if (isBranchD && cmpRes) begin
            w_pc_next = w_br_target;
        end
    end

    // PC and delay-slot flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
            r_bd <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            r_bd <= w_bd_next;
        end
    end

    assign pcF   = r_pc;
    assign bdF   = r_bd;
    // Illegal targets are fetched as-is; the fault is only flagged here.
    assign adelF = (r_pc[1:0] != 2'b00) || (r_pc < FETCH_LO) || (r_pc > FETCH_HI);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, excReq, eretD;
    logic [31:0] epc, pcD, jrTargetD;
    logic        isBranchD, cmpRes, isJD, isJrD;
    logic [15:0] imm16D;
    logic [25:0] index26D;
    logic [31:0] pcF;
    logic        bdF, adelF;

    int n_pass  = 0;
    int n_total = 0;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .excReq(excReq), .eretD(eretD),
        .epc(epc), .pcD(pcD), .isBranchD(isBranchD), .cmpRes(cmpRes), .isJD(isJD),
        .isJrD(isJrD), .imm16D(imm16D), .index26D(index26D), .jrTargetD(jrTargetD),
        .pcF(pcF), .bdF(bdF), .adelF(adelF)
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; excReq = 0; eretD = 0; epc = 0; pcD = 0; isBranchD = 0;
        cmpRes = 0; isJD = 0; isJrD = 0; imm16D = 0; index26D = 0; jrTargetD = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: priority list evaluated on architectural values.
    function automatic bit legal_fetch(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFC);
    endfunction

    task automatic test_reset();
        idle();
        reset = 1; excReq = 1; isJD = 1; index26D = 26'h3FFFFFF; stall = 1;
        tick(); tick();
        n_total++;
        if (pcF !== 32'h3000) $display("FAIL reset_pc: got %h want %h", pcF, 32'h3000);
        else n_pass++;
        n_total++;
        if (bdF !== 1'b0) $display("FAIL reset_bd: got %b want 0", bdF);
        else n_pass++;
        n_total++;
        if (adelF !== 1'b0) $display("FAIL reset_adel: got %b want 0", adelF);
        else n_pass++;
        idle();
    endtask

    task automatic test_sequential();
        reset = 0;
        #1;
        n_total++;
        if (pcF !== 32'h3000) $display("FAIL seq_pc0: got %h want 3000", pcF);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++;
            if (pcF !== 32'h3000 + 32'(4 * i) || bdF !== 1'b0)
                $display("FAIL seq_pc%0d: got %h/%b want %h/0", i, pcF, bdF, 32'h3000 + 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        pcD = 32'h3010; imm16D = 16'hFFFC; isBranchD = 1; cmpRes = 1;
        tick();
        n_total++;
        if (pcF !== 32'h3004 || bdF !== 1'b1)
            $display("FAIL branch_taken: got %h/%b want 00003004/1", pcF, bdF);
        else n_pass++;
        cmpRes = 0;
        tick();
        n_total++;
        if (pcF !== 32'h3008 || bdF !== 1'b1)
            $display("FAIL branch_not_taken: got %h/%b want 00003008/1", pcF, bdF);
        else n_pass++;
        idle();
    endtask

    task automatic test_jumps();
        isJD = 1; pcD = 32'h3020; index26D = 26'h0000C40;
        tick();
        n_total++;
        if (pcF !== 32'h3100 || bdF !== 1'b1)
            $display("FAIL jump: got %h/%b want 00003100/1", pcF, bdF);
        else n_pass++;
        isJD = 0; isJrD = 1; jrTargetD = 32'h3002;
        tick();
        n_total++;
        if (pcF !== 32'h3002 || adelF !== 1'b1)
            $display("FAIL jr_misaligned: got %h adel %b want 00003002 adel 1", pcF, adelF);
        else n_pass++;
        idle();
    endtask

    task automatic test_stall_exc();
        isBranchD = 1; cmpRes = 0;
        tick();
        n_total++;
        if (pcF !== 32'h3006 || bdF !== 1'b1)
            $display("FAIL pre_stall: got %h/%b want 00003006/1", pcF, bdF);
        else n_pass++;
        isBranchD = 0; stall = 1; isJD = 1; index26D = 26'h123;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (pcF !== 32'h3006 || bdF !== 1'b1)
                $display("FAIL stall_hold%0d: got %h/%b want 00003006/1", i, pcF, bdF);
            else n_pass++;
        end
        excReq = 1;
        tick();
        n_total++;
        if (pcF !== 32'h4180 || bdF !== 1'b0 || adelF !== 1'b0)
            $display("FAIL stall_exc: got %h/%b/%b want 00004180/0/0", pcF, bdF, adelF);
        else n_pass++;
        idle();
    endtask

    task automatic test_eret();
        eretD = 1; epc = 32'h3044; stall = 1; isJD = 1;
        tick();
        n_total++;
        if (pcF !== 32'h3044 || bdF !== 1'b0)
            $display("FAIL eret: got %h/%b want 00003044/0", pcF, bdF);
        else n_pass++;
        idle();
        isJrD = 1; jrTargetD = 32'h7000;
        tick();
        n_total++;
        if (pcF !== 32'h7000 || adelF !== 1'b1 || bdF !== 1'b1)
            $display("FAIL adel_7000: got %h adel %b bd %b want 00007000 1 1", pcF, adelF, bdF);
        else n_pass++;
        jrTargetD = 32'h6FFC;
        tick();
        n_total++;
        if (pcF !== 32'h6FFC || adelF !== 1'b0)
            $display("FAIL adel_6ffc: got %h adel %b want 00006ffc 0", pcF, adelF);
        else n_pass++;
        jrTargetD = 32'h2FFC;
        tick();
        n_total++;
        if (pcF !== 32'h2FFC || adelF !== 1'b1)
            $display("FAIL adel_2ffc: got %h adel %b want 00002ffc 1", pcF, adelF);
        else n_pass++;
        idle();
        eretD = 1; epc = 32'hFFFF_FFFC;
        tick();
        eretD = 0;
        tick();
        n_total++;
        if (pcF !== 32'h0000_0000 || adelF !== 1'b1)
            $display("FAIL pc_wrap: got %h adel %b want 00000000 1", pcF, adelF);
        else n_pass++;
        idle();
    endtask

    task automatic test_reset_midrun();
        isJD = 1; pcD = 32'h3020; index26D = 26'h0000C40;
        tick();
        n_total++;
        if (pcF !== 32'h3100 || bdF !== 1'b1)
            $display("FAIL midrun_setup: got %h/%b want 00003100/1", pcF, bdF);
        else n_pass++;
        @(negedge clk);
        reset = 1;
        #1;
        n_total++;
        if (pcF !== 32'h3000 || bdF !== 1'b0 || adelF !== 1'b0)
            $display("FAIL midrun_reset: got %h/%b/%b want 00003000/0/0", pcF, bdF, adelF);
        else n_pass++;
        @(negedge clk);
        reset = 0;
        idle();
        tick();
        n_total++;
        if (pcF !== 32'h3004 || bdF !== 1'b0)
            $display("FAIL after_reset: got %h/%b want 00003004/0", pcF, bdF);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] m_pc;
        logic        m_bd;
        logic [31:0] link;
        idle();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        m_pc = 32'h3000;
        m_bd = 1'b0;
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 5) == 0);
            excReq    = ($urandom_range(0, 15) == 0);
            eretD     = ($urandom_range(0, 12) == 0);
            epc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                                    : 32'h3000 + 32'($urandom_range(0, 16383));
            pcD       = 32'h3000 + 32'($urandom_range(0, 4095) * 4);
            if ($urandom_range(0, 9) == 0) pcD = $urandom;
            isBranchD = ($urandom_range(0, 3) == 0);
            cmpRes    = 1'($urandom);
            isJD      = ($urandom_range(0, 5) == 0);
            isJrD     = ($urandom_range(0, 5) == 0);
            imm16D    = 16'($urandom);
            index26D  = 26'($urandom);
            jrTargetD = ($urandom_range(0, 3) == 0) ? $urandom
                                                    : 32'h3000 + 32'($urandom_range(0, 4100) * 4);
            // Expected next state from the priority list.
            link = pcD + 32'd4;
            if (excReq) begin
                m_pc = 32'h4180; m_bd = 0;
            end else if (eretD) begin
                m_pc = epc; m_bd = 0;
            end else if (!stall) begin
                m_bd = isBranchD || isJD || isJrD;
                if (isJrD)                  m_pc = jrTargetD;
                else if (isJD)              m_pc = (link & 32'hF000_0000) + {6'd0, index26D} * 32'd4;
                else if (isBranchD && cmpRes) m_pc = link + 32'($signed(imm16D)) * 32'd4;
                else                        m_pc = m_pc + 32'd4;
            end
            tick();
            n_total++;
            if (pcF !== m_pc || bdF !== m_bd || adelF !== !legal_fetch(m_pc))
                $display("FAIL random_%0d: got %h/%b/%b want %h/%b/%b", i, pcF, bdF, adelF,
                         m_pc, m_bd, !legal_fetch(m_pc));
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_sequential();
        test_branch();
        test_jumps();
        test_stall_exc();
        test_eret();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces all state to reset values immediately.
REQ-004 stall  in  1  hazard-unit freeze of IF; hold PC and flags.
REQ-005 excReq  in  1  CP0 exception/interrupt request; redirect to handler.
REQ-006 eretD  in  1  eret in ID; redirect to EPC.
REQ-007 epc  in  32  EPC value from CP0.
REQ-008 pcD  in  32  PC of the instruction currently in ID.
REQ-009 isBranchD  in  1  ID holds beq/bne/blez/bgtz/bltz/bgez.
REQ-010 cmpRes  in  1  branch-condition result for the ID instruction, 1 = taken.
REQ-011 isJD  in  1  ID holds j or jal.
REQ-012 isJrD  in  1  ID holds jr or jalr.
REQ-013 imm16D  in  16  ID immediate field.
REQ-014 index26D  in  26  ID jump index field.
REQ-015 jrTargetD  in  32  forwarded rs value for jr/jalr.
REQ-016 pcF  out  32  fetch address to instruction memory.
REQ-017 bdF  out  1  instruction at pcF is in a branch delay slot.
REQ-018 adelF  out  1  fetch address error for pcF.

Function
REQ-019 State SHALL be exactly two registers: pc (32) and bd (1); pcF = pc and bdF = bd.
REQ-020 Constants: RESET_PC = 0x0000_3000; EXC_PC = 0x0000_4180; legal fetch range is 0x0000_3000..0x0000_6FFC.
REQ-021 Targets: branch = pcD + 4 + (sign-extended imm16D << 2), mod 2^32; jump = {(pcD+4)[31:28], index26D, 2'b00}; jr = jrTargetD unmodified.
REQ-022 Next-PC priority, highest first: excReq -> EXC_PC; eretD -> epc; stall -> hold; isJrD -> jr target; isJD -> jump target; isBranchD && cmpRes -> branch target; otherwise pc + 4.
REQ-023 excReq and eretD SHALL override stall; the PC is redirected in the same cycle they are sampled.
REQ-024 The branch, jump and jr selects SHALL be one-hot by decode; if more than one is asserted, the priority in REQ-022 applies.
REQ-025 When a non-stalled update occurs, bd SHALL load (isBranchD | isJD | isJrD), independent of cmpRes, because the delay slot always executes.
REQ-026 bd SHALL load 0 when excReq or eretD redirects, since no delay slot follows either redirect.
REQ-027 When stall is asserted without excReq or eretD, both pc and bd SHALL hold their values.
REQ-028 adelF SHALL be asserted combinationally when pc[1:0] != 0 or pc lies outside the legal range.
REQ-029 An illegal jr target SHALL still be loaded into pc; the fault is reported only through adelF and is not corrected.
REQ-030 pc + 4 SHALL wrap modulo 2^32 with no overflow flag.
REQ-031 The unit SHALL raise no exception itself; excReq is purely an input.

Reset
REQ-032 On reset assertion, pc = 0x0000_3000 and bd = 0 asynchronously, so adelF = 0.
REQ-033 Reset SHALL dominate every other input, including excReq.
REQ-034 On the first rising edge after reset deasserts, with no other inputs active, pc SHALL become 0x0000_3004.

Verification
REQ-035 Sequential fetch: release reset, hold all controls 0 for 3 cycles -> pcF = 0x3000, 0x3004, 0x3008, 0x300C; bdF = 0 throughout.
REQ-036 Taken branch: pcD = 0x3010, imm16D = 0xFFFC, isBranchD = 1, cmpRes = 1 -> next pcF = 0x3004 and bdF = 1; with cmpRes = 0 -> pcF = pc + 4 and bdF = 1.
REQ-037 Jumps: isJD = 1, pcD = 0x3020, index26D = 0x0000C40 -> pcF = 0x0000_3100; isJrD = 1, jrTargetD = 0x3002 -> pcF = 0x3002 and adelF = 1.
REQ-038 Stall vs. exception: stall = 1 for 2 cycles -> pcF and bdF hold; stall = 1 with excReq = 1 -> pcF = 0x4180 and bdF = 0 on the next edge.
REQ-039 eret: eretD = 1, epc = 0x3044, stall = 1 -> pcF = 0x3044 and bdF = 0; fetch address 0x7000 -> adelF = 1.
REQ-040 Reset mid-run: assert reset asynchronously while pcF = 0x3100 and bdF = 1 -> pcF = 0x3000 and bdF = 0 before the next clock edge.
